window_read_sequencer: RTL and testbench
========================================

Name: window_read_sequencer

Overview:
Downstream consumer of the image-spec register stage. Takes the latched image geometry (n_colum, n_row) and walks the frame in SDRAM as 3-row column triplets (top/mid/bot) for each output row, issuing single-word Avalon-MM reads. Delivers one {top, mid, bot} pixel triplet per column to the 3x3 window/filter stage over a valid/ready handshake. Pixels are 32-bit words stored row-major, with row stride n_colum*4 bytes.

Parameters:
BASE_ADDR, 32'h08000000, byte address of pixel (0,0).
BYTES_PER_PIXEL, 4, address increment per column; row stride is n_colum*BYTES_PER_PIXEL.

Ports:
clk  in  1  clock.
n_rst  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle pulse; begin a frame using the current n_colum and n_row.
n_colum  in  16  image width in pixels.
n_row  in  16  image height in pixels.
avm_address  out  32  Avalon read byte address.
avm_read  out  1  Avalon read request.
avm_waitrequest  in  1  slave stall.
avm_readdata  in  32  read data.
avm_readdatavalid  in  1  read data qualifier.
col_valid  out  1  triplet available.
col_ready  in  1  downstream accepts triplet.
col_top, col_mid, col_bot  out  32 each  pixel triplet.
col_first  out  1  triplet is column 0.
col_last  out  1  triplet is column n_colum-1.
busy  out  1  high from start acceptance until done.
done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset: FSM=IDLE; all outputs 0; counters, address and data registers cleared. Reset mid-frame aborts immediately. No reads are reissued after reset release.
- On start in IDLE: latch n_colum and n_row into shadow registers (inputs are ignored until the next start).
  - Set row_base=BASE_ADDR, col=0, row=0, busy=1.
  - start while busy is ignored.
- Degenerate frames: n_row<3 or n_colum==0 at start. Go to DONE with zero reads; done pulses the cycle after start.
- FSM states:
  - IDLE -> RD_TOP on start.
  - RD_TOP -> RD_MID.
  - RD_MID -> RD_BOT.
  - RD_BOT -> PRESENT.
  - PRESENT -> RD_TOP (next column or next row) or DONE.
  - DONE -> IDLE.
- Read states:
  - Only one read is outstanding at a time.
  - Each RD_x state drives avm_read=1 with its address until a cycle with avm_waitrequest=0. Address and read are held stable while waitrequest=1.
  - After acceptance, avm_read=0 and the block waits for avm_readdatavalid. It captures avm_readdata into the top/mid/bot register, then advances to the next state.
  - readdatavalid with no outstanding read is ignored.
- Addresses:
  - pix = row_base + col*BYTES_PER_PIXEL.
  - top=pix; mid=pix+n_colum*4; bot=pix+n_colum*8.
  - All arithmetic is 32-bit, modulo 2^32.
  - row_base is kept incrementally (row_base += n_colum*4 per row advance). No full row*col multiply.
- First request latency: avm_read is asserted the cycle after start is accepted.
- PRESENT:
  - col_valid=1; col_first=(col==0); col_last=(col==n_colum-1).
  - Data holds stable until col_valid&&col_ready.
  - On handshake, if col<n_colum-1: col++ and go to RD_TOP.
  - On handshake at the last column with row<n_row-3: col=0, row++, row_base+=stride, go to RD_TOP.
  - On handshake at the last column of the last row: go to DONE.
- DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- Totals: a frame produces (n_row-2)*n_colum triplets and 3x that many reads.

Decomposition:
- Package image_pkg holds:
  - IMG_BASE_ADDR (32'h08000000) and BYTES_PER_PIXEL (4).
  - Enum seq_state_t: IDLE, RD_TOP, RD_MID, RD_BOT, PRESENT, DONE.
  - Triplet struct col_triplet_t {top, mid, bot}.
- One sub-module, window_coord_counter. It holds col, row and row_base, with inputs step_col and step_row, and outputs col_last, frame_last and pix_addr.

Test Plan:
1. n_colum=4, n_row=3, start, waitrequest=0, readdatavalid 1 cycle after accept, col_ready=1 -> 12 reads in order 0x08000000, 0x08000010, 0x08000020, 0x08000004, 0x08000014, 0x08000024, ... 0x0800002C. Result: 4 triplets, col_first on the 1st, col_last on the 4th, then one done pulse.
2. n_colum=2, n_row=4 -> 4 triplets. The second row's first triplet reads addresses 0x08000008, 0x08000010, 0x08000018.
3. waitrequest held high for 3 cycles on the mid read -> avm_address stays 0x08000010 and avm_read stays 1 for all 4 cycles. Exactly one read is accepted.
4. col_ready low for 5 cycles in PRESENT -> col_valid and triplet data are held. No new avm_read until the handshake completes.
5. n_row=2 (and separately n_colum=0) -> zero reads, done the cycle after start. A start pulse asserted while busy is ignored.
6. n_rst asserted during RD_MID of frame 1 -> all outputs 0 and FSM in IDLE. A new start after reset re-runs scenario 1 identically.

Source files
------------

// File: rtl/image_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | image_pkg: shared frame geometry constants, sequencer states, triplet type |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package image_pkg;

  localparam logic [31:0] IMG_BASE_ADDR   = 32'h0800_0000;
  localparam int          BYTES_PER_PIXEL = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_TOP  = 3'd1,
    RD_MID  = 3'd2,
    RD_BOT  = 3'd3,
    PRESENT = 3'd4,
    DONE    = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic [31:0] top;
    logic [31:0] mid;
    logic [31:0] bot;
  } col_triplet_t;

endpackage
`default_nettype wire

// File: rtl/window_coord_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | window_coord_counter: column/row position and top-pixel byte address       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module window_coord_counter #(
  parameter logic [31:0] BASE_ADDR       = image_pkg::IMG_BASE_ADDR,
  parameter int          BYTES_PER_PIXEL = image_pkg::BYTES_PER_PIXEL
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        init,
  input  logic        step_col,
  input  logic        step_row,
  input  logic [15:0] n_colum,
  input  logic [15:0] n_row,
  output logic        col_first,
  output logic        col_last,
  output logic        frame_last,
  output logic [31:0] pix_addr,
  output logic [31:0] next_pix_addr,
  output logic [31:0] stride
);
  import image_pkg::*;

  localparam logic [31:0] C_PIX_STEP = 32'(BYTES_PER_PIXEL);

  logic [15:0] r_col;
  logic [15:0] r_row;
  logic [31:0] r_row_base;
  logic [31:0] r_col_off;

  assign stride        = {16'd0, n_colum} * C_PIX_STEP;
  assign col_first     = (r_col == 16'd0);
  assign col_last      = (r_col == n_colum - 16'd1);
  assign frame_last    = (r_row == n_row - 16'd3);
  assign pix_addr      = r_row_base + r_col_off;
  // Address of the pixel that follows the current one in walk order
  assign next_pix_addr = col_last ? (r_row_base + stride) : (pix_addr + C_PIX_STEP);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
      r_col_off  <= '0;
    end else if (init) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= BASE_ADDR;
      r_col_off  <= '0;
    end else if (step_row) begin
      r_col      <= '0;
      r_row      <= r_row + 16'd1;
      r_row_base <= r_row_base + stride;
      r_col_off  <= '0;
    end else if (step_col) begin
      r_col      <= r_col + 16'd1;
      r_col_off  <= r_col_off + C_PIX_STEP;
    end
  end

endmodule
`default_nettype wire

// File: rtl/window_read_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | window_read_sequencer: walks a frame as 3-row column triplets over Avalon  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module window_read_sequencer #(
  parameter logic [31:0] BASE_ADDR       = image_pkg::IMG_BASE_ADDR,
  parameter int          BYTES_PER_PIXEL = image_pkg::BYTES_PER_PIXEL
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [15:0] n_colum,
  input  logic [15:0] n_row,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        col_valid,
  input  logic        col_ready,
  output logic [31:0] col_top,
  output logic [31:0] col_mid,
  output logic [31:0] col_bot,
  output logic        col_first,
  output logic        col_last,
  output logic        busy,
  output logic        done
);
  import image_pkg::*;

  seq_state_t   r_state;
  logic         r_pending;
  logic [15:0]  r_n_colum;
  logic [15:0]  r_n_row;
  logic [31:0]  r_top;
  logic [31:0]  r_mid;
  col_triplet_t r_trip;

  logic        w_init;
  logic        w_step_col;
  logic        w_step_row;
  logic        w_degenerate;
  logic        w_col_first;
  logic        w_col_last;
  logic        w_frame_last;
  logic [31:0] w_pix_addr;
  logic [31:0] w_next_pix;
  logic [31:0] w_stride;

  assign w_degenerate = (n_row < 16'd3) || (n_colum == 16'd0);
  assign w_init       = (r_state == IDLE) && start;
  assign w_step_col   = (r_state == PRESENT) && col_ready && !w_col_last;
  assign w_step_row   = (r_state == PRESENT) && col_ready && w_col_last && !w_frame_last;

  assign col_top = r_trip.top;
  assign col_mid = r_trip.mid;
  assign col_bot = r_trip.bot;

  window_coord_counter #(
    .BASE_ADDR       (BASE_ADDR),
    .BYTES_PER_PIXEL (BYTES_PER_PIXEL)
  ) u_coord (
    .clk           (clk),
    .n_rst         (n_rst),
    .init          (w_init),
    .step_col      (w_step_col),
    .step_row      (w_step_row),
    .n_colum       (r_n_colum),
    .n_row         (r_n_row),
    .col_first     (w_col_first),
    .col_last      (w_col_last),
    .frame_last    (w_frame_last),
    .pix_addr      (w_pix_addr),
    .next_pix_addr (w_next_pix),
    .stride        (w_stride)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_pending   <= 1'b0;
      r_n_colum   <= '0;
      r_n_row     <= '0;
      r_top       <= '0;
      r_mid       <= '0;
      r_trip      <= '0;
      avm_address <= '0;
      avm_read    <= 1'b0;
      col_valid   <= 1'b0;
      col_first   <= 1'b0;
      col_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_n_colum <= n_colum;
            r_n_row   <= n_row;
            if (w_degenerate) begin
              r_state <= DONE;
              done    <= 1'b1;
            end else begin
              r_state     <= RD_TOP;
              busy        <= 1'b1;
              avm_read    <= 1'b1;
              avm_address <= BASE_ADDR;
            end
          end
        end
        RD_TOP, RD_MID, RD_BOT: begin
          // Request phase until accepted, then wait for the single data beat
          if (avm_read) begin
            if (!avm_waitrequest) begin
              avm_read  <= 1'b0;
              r_pending <= 1'b1;
            end
          end else if (r_pending && avm_readdatavalid) begin
            r_pending <= 1'b0;
            if (r_state == RD_TOP) begin
              r_top       <= avm_readdata;
              r_state     <= RD_MID;
              avm_read    <= 1'b1;
              avm_address <= w_pix_addr + w_stride;
            end else if (r_state == RD_MID) begin
              r_mid       <= avm_readdata;
              r_state     <= RD_BOT;
              avm_read    <= 1'b1;
              avm_address <= w_pix_addr + (w_stride << 1);
            end else begin
              r_trip    <= '{top: r_top, mid: r_mid, bot: avm_readdata};
              col_valid <= 1'b1;
              col_first <= w_col_first;
              col_last  <= w_col_last;
              r_state   <= PRESENT;
            end
          end
        end
        PRESENT: begin
          if (col_ready) begin
            col_valid <= 1'b0;
            col_first <= 1'b0;
            col_last  <= 1'b0;
            if (w_col_last && w_frame_last) begin
              r_state <= DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_state     <= RD_TOP;
              avm_read    <= 1'b1;
              avm_address <= w_next_pix;
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_read_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_window_read_sequencer: randomized Avalon slave and frame reference model|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_window_read_sequencer;

  localparam logic [31:0] C_BASE = 32'h0800_0000;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] n_colum = '0;
  logic [15:0] n_row = '0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        col_valid;
  logic        col_ready = 1'b0;
  logic [31:0] col_top, col_mid, col_bot;
  logic        col_first, col_last, busy, done;

  always #5 clk = ~clk;

  window_read_sequencer dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .start             (start),
    .n_colum           (n_colum),
    .n_row             (n_row),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .col_valid         (col_valid),
    .col_ready         (col_ready),
    .col_top           (col_top),
    .col_mid           (col_mid),
    .col_bot           (col_bot),
    .col_first         (col_first),
    .col_last          (col_last),
    .busy              (busy),
    .done              (done)
  );

  typedef struct packed {
    logic [31:0] top;
    logic [31:0] mid;
    logic [31:0] bot;
    logic        first;
    logic        last;
  } trip_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_addr_q[$];
  trip_t       exp_trip_q[$];

  int stall_pct = 0;
  int ready_pct = 100;
  int max_lat = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference: the frame is the list of output rows 0..n_row-3, each visiting every column
  task automatic build_model(input int nc, input int nr);
    logic [31:0] pix;
    logic [31:0] stride;
    trip_t t;
    exp_addr_q.delete();
    exp_trip_q.delete();
    if (nr < 3 || nc == 0) return;
    stride = 32'(nc * 4);
    for (int r = 0; r <= nr - 3; r++) begin
      for (int c = 0; c < nc; c++) begin
        pix = C_BASE + 32'((r * nc + c) * 4);
        exp_addr_q.push_back(pix);
        exp_addr_q.push_back(pix + stride);
        exp_addr_q.push_back(pix + 2 * stride);
        t.top   = mem_word(pix);
        t.mid   = mem_word(pix + stride);
        t.bot   = mem_word(pix + 2 * stride);
        t.first = (c == 0);
        t.last  = (c == nc - 1);
        exp_trip_q.push_back(t);
      end
    end
  endtask

  // Avalon slave plus downstream consumer, all acting on the falling edge
  bit          outstanding = 0;
  bit          had_out;
  int          lat = 0;
  logic [31:0] out_addr = '0;
  bit          prev_stall = 0;
  logic [31:0] prev_addr = '0;
  bit          prev_valid = 0;
  bit          prev_hs = 0;
  trip_t       prev_trip;
  trip_t       got;

  initial begin
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        outstanding       = 0;
        prev_stall        = 0;
        prev_valid        = 0;
        prev_hs           = 0;
        avm_waitrequest   = 0;
        avm_readdatavalid = 0;
        col_ready         = 0;
        continue;
      end
      had_out = outstanding;
      avm_readdatavalid = 0;
      avm_readdata = $urandom;
      if (outstanding) begin
        if (lat == 0) begin
          avm_readdatavalid = 1;
          avm_readdata = mem_word(out_addr);
          outstanding = 0;
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        avm_readdatavalid = 1;
      end

      if (prev_stall) begin
        check("read_held", avm_read, 1);
        check("addr_held", avm_address, prev_addr);
      end
      prev_stall = 0;
      if (avm_read) begin
        check("single_outstanding", had_out, 0);
        avm_waitrequest = ($urandom_range(0, 99) < stall_pct);
        if (avm_waitrequest) begin
          prev_stall = 1;
          prev_addr  = avm_address;
        end else begin
          check("read_expected", exp_addr_q.size() != 0, 1);
          if (exp_addr_q.size() != 0) check("read_addr", avm_address, exp_addr_q.pop_front());
          outstanding = 1;
          out_addr    = avm_address;
          lat         = $urandom_range(0, max_lat);
        end
      end else begin
        avm_waitrequest = $urandom_range(0, 1);
      end

      got = '{top: col_top, mid: col_mid, bot: col_bot, first: col_first, last: col_last};
      if (prev_valid && !prev_hs) begin
        check("valid_held", col_valid, 1);
        check("trip_held", (got == prev_trip), 1);
      end
      col_ready = ($urandom_range(0, 99) < ready_pct);
      if (col_valid) begin
        check("no_read_in_present", avm_read, 0);
        if (col_ready) begin
          check("trip_expected", exp_trip_q.size() != 0, 1);
          if (exp_trip_q.size() != 0) begin
            trip_t e;
            e = exp_trip_q.pop_front();
            check("col_top", col_top, e.top);
            check("col_mid", col_mid, e.mid);
            check("col_bot", col_bot, e.bot);
            check("col_first", col_first, e.first);
            check("col_last", col_last, e.last);
          end
        end
      end
      prev_trip  = got;
      prev_valid = col_valid;
      prev_hs    = col_valid && col_ready;
    end
  end

  task automatic run_frame(input int nc, input int nr, input bit mid_start);
    bit degen;
    bit seen;
    degen = (nr < 3) || (nc == 0);
    build_model(nc, nr);
    @(negedge clk);
    n_colum = 16'(nc);
    n_row   = 16'(nr);
    start   = 1;
    @(negedge clk);
    start   = 0;
    n_colum = 16'($urandom);
    n_row   = 16'($urandom);
    if (degen) begin
      check("degen_done", done, 1);
      check("degen_busy", busy, 0);
      check("degen_read", avm_read, 0);
      @(negedge clk);
      check("done_pulse", done, 0);
      repeat (3) @(negedge clk);
      return;
    end
    check("first_read", avm_read, 1);
    check("busy_set", busy, 1);
    seen = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      start = mid_start && (cyc == 3);
      if (start) begin
        n_colum = 16'($urandom_range(0, 9));
        n_row   = 16'($urandom_range(0, 9));
      end
      if (done) begin
        seen = 1;
        break;
      end
    end
    start = 0;
    check("frame_done_seen", seen, 1);
    check("busy_at_done", busy, 0);
    check("reads_left", exp_addr_q.size(), 0);
    check("trips_left", exp_trip_q.size(), 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_read", avm_read, 0);
    check("rst_addr", avm_address, 0);
    check("rst_valid", col_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_top", col_top, 0);
    n_rst = 1;

    run_frame(4, 3, 0);
    run_frame(2, 4, 0);

    stall_pct = 50; ready_pct = 40; max_lat = 2;
    run_frame(3, 5, 1);
    run_frame(5, 2, 0);
    run_frame(0, 7, 0);
    for (int i = 0; i < 10; i++) begin
      run_frame($urandom_range(0, 9), $urandom_range(1, 7), 1'($urandom_range(0, 1)));
    end

    // Abort in the middle of the first mid read, then re-run the same frame
    stall_pct = 0; ready_pct = 100; max_lat = 0;
    build_model(4, 3);
    @(negedge clk);
    n_colum = 16'd4; n_row = 16'd3; start = 1;
    @(negedge clk);
    start = 0;
    seen = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (avm_read && avm_address == 32'h0800_0010) begin
        seen = 1;
        break;
      end
    end
    check("reached_rd_mid", seen, 1);
    #2 n_rst = 0;
    #1;
    check("abort_read", avm_read, 0);
    check("abort_addr", avm_address, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", col_valid, 0);
    check("abort_bot", col_bot, 0);
    exp_addr_q.delete();
    exp_trip_q.delete();
    repeat (2) @(negedge clk);
    #2 n_rst = 1;
    repeat (6) @(negedge clk);
    check("idle_after_abort", busy, 0);
    run_frame(4, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
